id_stage: RTL
=============

// Module: id_stage
// PURPOSE
//  Instruction-decode stage directly downstream of instruction fetch. Holds the IF/ID pipeline
//  register, 32x32 register file, RV32I immediate generator, control decoder and load-use hazard
//  detector. Produces operands/controls for EX. Returns pc_write and the JAL redirect to fetch.
// PARAMETERS
//  NOP_INSTR   32'h0000_0013   instruction loaded into IF/ID on reset/flush (addi x0,x0,0)
//  RESET_PC    32'h0000_0000   id_pc value after reset/flush
// PORTS
//  clk            in   1   rising-edge clock
//  reset          in   1   synchronous, active-high
//  if_instruction in   32  instruction from fetch
//  if_pc          in   32  PC of if_instruction
//  flush          in   1   EX resolved taken branch/JALR; kill IF/ID content
//  ex_mem_read    in   1   instruction now in EX is a load
//  ex_rd          in   5   destination of instruction in EX
//  wb_reg_write   in   1   write-back enable
//  wb_rd          in   5   write-back register
//  wb_data        in   32  write-back data
//  pc_write       out  1   1 = fetch may update PC; 0 = hold (load-use stall)
//  jal            out  1   redirect fetch to jal_addr
//  jal_addr       out  32  id_pc + J-immediate
//  id_pc          out  32  PC of decoded instruction
//  id_rs1_data    out  32  register rs1 value
//  id_rs2_data    out  32  register rs2 value
//  id_imm         out  32  sign-extended immediate
//  id_rs1/id_rs2/id_rd out 5 register indices
//  id_funct3      out  3   instr[14:12]
//  id_funct7b5    out  1   instr[30]
//  id_reg_write, id_mem_read, id_mem_write, id_branch, id_jalr, id_alu_src  out 1 each
//  id_wb_sel      out  2   00 ALU, 01 memory, 10 PC+4
//  id_illegal     out  1   valid instruction with unsupported opcode
// BEHAVIOUR
//  IF/ID register (instr, pc, valid), priority per clk edge:
//   reset -> NOP_INSTR, RESET_PC, valid=0; flush or jal -> same NOP load; stall -> hold; else
//   load if_instruction/if_pc, valid=1.
//  Decode outputs combinational from IF/ID register (0 cycles past it; 1 cycle after fetch).
//  Immediates: I,S,B,U,J per RV32I, sign-extended from instr[31]; B/J bit0=0; other opcodes 0.
//  Opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111,
//   JALR 1100111, LUI 0110111, AUIPC 0010111. Anything else: all controls 0, id_illegal=valid.
//  Register file: x0 reads 0, never written. Write on clk edge if wb_reg_write && wb_rd!=0.
//   Same-cycle read of wb_rd (!=0) while writing returns wb_data (write-through bypass).
//   reset clears all 32 registers.
//  Hazard: stall = valid && ex_mem_read && ex_rd!=0 && ((rs1 used && ex_rd==rs1) ||
//   (rs2 used && ex_rd==rs2)). rs2 used by R/STORE/BRANCH; rs1 by all except LUI/AUIPC/JAL.
//   While stall: pc_write=0, IF/ID holds, all id_* control strobes forced 0 (bubble).
//  flush overrides stall: pc_write=1, controls 0, jal=0.
//  jal = valid && opcode==JAL && !flush (JAL never stalls); jal_addr wraps modulo 2^32.
//  Reset outputs: pc_write=1, jal=0, all controls 0, id_pc=RESET_PC, id_illegal=0.
//  Reset mid-stall: stall clears next cycle since valid=0.
// TESTING
//  reset 2 cycles -> id_pc=0, all controls 0, pc_write=1, rs data 0 for all regs.
//  wb x5=32'hDEAD_BEEF, same cycle decode add x1,x5,x0 -> id_rs1_data=DEADBEEF; wb x0 -> reads 0.
//  lw x3 in EX (ex_mem_read=1,ex_rd=3), ID=add x4,x3,x2 -> pc_write=0 one cycle, controls 0,
//   IF/ID held; with ex_rd=0 -> no stall.
//  JAL x1,-8 at pc=0x100 -> jal=1, jal_addr=0xF8, next cycle IF/ID = NOP, valid=0.
//  flush=1 during a stall -> pc_write=1, next cycle IF/ID = NOP.
//  sw x2,-4(x1) -> id_imm=32'hFFFF_FFFC, mem_write=1, reg_write=0; opcode 0000000 -> illegal=1.

Source files
------------

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: IF/ID register, 32x32 register file, immediate
// generator, control decoder and load-use hazard detection feeding EX.
module id_stage #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] if_instruction,
   input  logic [31:0] if_pc,
   input  logic        flush,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rd,
   input  logic        wb_reg_write,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   output logic        pc_write,
   output logic        jal,
   output logic [31:0] jal_addr,
   output logic [31:0] id_pc,
   output logic [31:0] id_rs1_data,
   output logic [31:0] id_rs2_data,
   output logic [31:0] id_imm,
   output logic [4:0]  id_rs1,
   output logic [4:0]  id_rs2,
   output logic [4:0]  id_rd,
   output logic [2:0]  id_funct3,
   output logic        id_funct7b5,
   output logic        id_reg_write,
   output logic        id_mem_read,
   output logic        id_mem_write,
   output logic        id_branch,
   output logic        id_jalr,
   output logic        id_alu_src,
   output logic [1:0]  id_wb_sel,
   output logic        id_illegal
);

   typedef enum logic [6:0] {
      OP_R      = 7'b0110011,
      OP_IMM    = 7'b0010011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_BRANCH = 7'b1100011,
      OP_JAL    = 7'b1101111,
      OP_JALR   = 7'b1100111,
      OP_LUI    = 7'b0110111,
      OP_AUIPC  = 7'b0010111
   } opcode_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'b00,
      WB_MEM = 2'b01,
      WB_PC4 = 2'b10
   } wb_sel_e;

   logic [31:0] instr_q, instr_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic [31:0] rf_q [32];

   opcode_e     opcode;
   logic [4:0]  rs1, rs2;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic        rs1_used, rs2_used;
   logic        stall, kill, jal_hit;

   logic        c_reg_write, c_mem_read, c_mem_write, c_branch, c_jalr, c_alu_src, c_illegal;
   wb_sel_e     c_wb_sel;
   logic [31:0] c_imm;

   assign opcode = opcode_e'(instr_q[6:0]);
   assign rs1    = instr_q[19:15];
   assign rs2    = instr_q[24:20];

   assign imm_i = {{20{instr_q[31]}}, instr_q[31:20]};
   assign imm_s = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
   assign imm_b = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
   assign imm_u = {instr_q[31:12], 12'b0};
   assign imm_j = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};

   always_comb begin
      c_reg_write = 1'b0;
      c_mem_read  = 1'b0;
      c_mem_write = 1'b0;
      c_branch    = 1'b0;
      c_jalr      = 1'b0;
      c_alu_src   = 1'b0;
      c_wb_sel    = WB_ALU;
      c_illegal   = 1'b0;
      c_imm       = '0;
      rs1_used    = 1'b1;
      rs2_used    = 1'b0;
      case (opcode)
         OP_R: begin
            c_reg_write = 1'b1;
            rs2_used    = 1'b1;
         end
         OP_IMM: begin
            c_reg_write = 1'b1;
            c_alu_src   = 1'b1;
            c_imm       = imm_i;
         end
         OP_LOAD: begin
            c_reg_write = 1'b1;
            c_mem_read  = 1'b1;
            c_alu_src   = 1'b1;
            c_wb_sel    = WB_MEM;
            c_imm       = imm_i;
         end
         OP_STORE: begin
            c_mem_write = 1'b1;
            c_alu_src   = 1'b1;
            c_imm       = imm_s;
            rs2_used    = 1'b1;
         end
         OP_BRANCH: begin
            c_branch    = 1'b1;
            c_imm       = imm_b;
            rs2_used    = 1'b1;
         end
         OP_JAL: begin
            c_reg_write = 1'b1;
            c_wb_sel    = WB_PC4;
            c_imm       = imm_j;
            rs1_used    = 1'b0;
         end
         OP_JALR: begin
            c_reg_write = 1'b1;
            c_jalr      = 1'b1;
            c_alu_src   = 1'b1;
            c_wb_sel    = WB_PC4;
            c_imm       = imm_i;
         end
         OP_LUI: begin
            c_reg_write = 1'b1;
            c_alu_src   = 1'b1;
            c_imm       = imm_u;
            rs1_used    = 1'b0;
         end
         OP_AUIPC: begin
            c_reg_write = 1'b1;
            c_alu_src   = 1'b1;
            c_imm       = imm_u;
            rs1_used    = 1'b0;
         end
         default: c_illegal = 1'b1;
      endcase
   end

   assign stall = valid_q && ex_mem_read && (ex_rd != '0) &&
                  ((rs1_used && (ex_rd == rs1)) || (rs2_used && (ex_rd == rs2)));
   // flush outranks the stall: the stalled instruction is being discarded anyway
   assign kill     = stall || flush;
   assign pc_write = !(stall && !flush);
   assign jal_hit  = valid_q && (opcode == OP_JAL) && !flush;
   assign jal      = jal_hit;
   assign jal_addr = pc_q + imm_j;

   always_comb begin
      instr_d = instr_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      if (flush || jal_hit) begin
         instr_d = NOP_INSTR;
         pc_d    = RESET_PC;
         valid_d = 1'b0;
      end else if (!stall) begin
         instr_d = if_instruction;
         pc_d    = if_pc;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q <= NOP_INSTR;
         pc_q    <= RESET_PC;
         valid_q <= 1'b0;
      end else begin
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < 32; i++) begin
            rf_q[i] <= '0;
         end
      end else if (wb_reg_write && (wb_rd != '0)) begin
         rf_q[wb_rd] <= wb_data;
      end
   end

   // write-through bypass lets WB and ID share a cycle without a forwarding path
   always_comb begin
      id_rs1_data = rf_q[rs1];
      id_rs2_data = rf_q[rs2];
      if (rs1 == '0) begin
         id_rs1_data = '0;
      end else if (!reset && wb_reg_write && (wb_rd == rs1)) begin
         id_rs1_data = wb_data;
      end
      if (rs2 == '0) begin
         id_rs2_data = '0;
      end else if (!reset && wb_reg_write && (wb_rd == rs2)) begin
         id_rs2_data = wb_data;
      end
   end

   assign id_pc       = pc_q;
   assign id_imm      = c_imm;
   assign id_rs1      = rs1;
   assign id_rs2      = rs2;
   assign id_rd       = instr_q[11:7];
   assign id_funct3   = instr_q[14:12];
   assign id_funct7b5 = instr_q[30];

   always_comb begin
      id_reg_write = 1'b0;
      id_mem_read  = 1'b0;
      id_mem_write = 1'b0;
      id_branch    = 1'b0;
      id_jalr      = 1'b0;
      id_alu_src   = 1'b0;
      id_wb_sel    = WB_ALU;
      id_illegal   = 1'b0;
      if (valid_q && !kill) begin
         id_reg_write = c_reg_write;
         id_mem_read  = c_mem_read;
         id_mem_write = c_mem_write;
         id_branch    = c_branch;
         id_jalr      = c_jalr;
         id_alu_src   = c_alu_src;
         id_wb_sel    = c_wb_sel;
         id_illegal   = c_illegal;
      end
   end

endmodule
